// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fb_pkg;

  // Default raster geometry; the top level can override both per instance.
  localparam int FB_H_RES  = 160;
  localparam int FB_V_RES  = 120;
  localparam int FB_PIXELS = FB_H_RES * FB_V_RES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fb_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO buffering accepted pixels ahead of the write port.
// Latency: a pushed entry is visible at pop_data the cycle after the push.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
//
// Ports: clk/reset (async active-high), clr (synchronous flush),
//        push/push_data, pop/pop_data (head, show-ahead), full/empty flags.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Writes a raster frame of RGB332 pixels into framebuffer memory, row-major.
// Latency: pixel accepted at edge n (FIFO and output register empty) shows fb_we=1 after edge n+1.
// Backpressure: fb_ready stalls the write port; the source cannot be stalled, so pixels arriving with the FIFO full are dropped and flagged in overflow.
//
// Ports: clk, reset (async active-high), start (arms a frame in IDLE),
//        pixel_data/pixel_valid (input stream), fb_we/fb_addr/fb_wdata/fb_ready
//        (memory write port), busy, frame_done (1-cycle pulse), overflow (sticky).
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int H_RES      = FB_H_RES,
  parameter int V_RES      = FB_V_RES,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        pixel_data,
  input  logic              pixel_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic              fb_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(H_RES + 1);
  localparam int YW    = $clog2(V_RES + 1);

  fb_state_t   state;
  logic [CW-1:0] acc_cnt;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;

  logic       hs;
  logic       start_frame;
  logic       want_push;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       drop;
  logic       last_write;

  assign hs          = fb_we && fb_ready;
  assign start_frame = (state == IDLE) && start;

  // A pixel is a candidate only while the frame still needs pixels.
  assign want_push   = (state == FILL) && pixel_valid && (acc_cnt < CW'(TOTAL));

  // Output register refills whenever it is empty or is draining this edge.
  assign fifo_pop    = !fifo_empty && (!fb_we || hs);
  assign fifo_push   = want_push && (!fifo_full || fifo_pop);
  assign drop        = want_push && fifo_full && !fifo_pop;

  // x/y track the pixel currently held in the output register.
  assign last_write  = hs && (wr_x == XW'(H_RES - 1)) && (wr_y == YW'(V_RES - 1));

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_frame),
    .push      (fifo_push),
    .push_data (pixel_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame control FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            state    <= FILL;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        FILL: begin
          if (drop) overflow <= 1'b1;
          if (last_write) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  // Accept counter, raster counters and the write-port register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt  <= '0;
      wr_x     <= '0;
      wr_y     <= '0;
      fb_addr  <= '0;
      fb_we    <= 1'b0;
      fb_wdata <= '0;
    end else if (start_frame) begin
      acc_cnt  <= '0;
      wr_x     <= '0;
      wr_y     <= '0;
      fb_addr  <= '0;
      fb_we    <= 1'b0;
    end else begin
      if (fifo_push) acc_cnt <= acc_cnt + 1'b1;

      // Linear address runs alongside x/y, avoiding a y*H_RES multiply.
      if (hs) begin
        fb_addr <= fb_addr + 1'b1;
        if (wr_x == XW'(H_RES - 1)) begin
          wr_x <= '0;
          wr_y <= wr_y + 1'b1;
        end else begin
          wr_x <= wr_x + 1'b1;
        end
      end

      if (fifo_pop) begin
        fb_we    <= 1'b1;
        fb_wdata <= fifo_dout;
      end else if (hs) begin
        fb_we    <= 1'b0;
      end
    end
  end

endmodule
